// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer owning the PC and a one-entry decode buffer.
// Latency: a fetch completes on the imem_ack edge; the buffered instruction is valid the next cycle.
// Backpressure: no new fetch starts while the buffer is full and id_ready is low; requests are never withdrawn.
//
// Ports:
//   CLK, reset              clock and synchronous active-high reset
//   imem_req/addr/ack/rdata instruction-memory request/response handshake
//   if_valid/inst/pc        buffered instruction presented to decode
//   id_ready                decode consumes the buffered instruction
//   redirect/redirect_pc    branch/jump taken and its target
//   trap                    exception, loads TRAP_VEC (wins over redirect)
//   pc                      current fetch PC (registered)
module fetch_seq #(
  parameter int                  WORDSIZE  = 32,
  parameter logic [WORDSIZE-1:0] RESET_VEC = '0,
  parameter logic [WORDSIZE-1:0] TRAP_VEC  = WORDSIZE'(32'h00000100)
) (
  input  logic                CLK,
  input  logic                reset,
  output logic                imem_req,
  output logic [WORDSIZE-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORDSIZE-1:0] imem_rdata,
  output logic                if_valid,
  output logic [WORDSIZE-1:0] if_inst,
  output logic [WORDSIZE-1:0] if_pc,
  input  logic                id_ready,
  input  logic                redirect,
  input  logic [WORDSIZE-1:0] redirect_pc,
  input  logic                trap,
  output logic [WORDSIZE-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORDSIZE-1:0] pc_q, pc_d;
  logic [WORDSIZE-1:0] pend_q, pend_d;
  logic                ifv_q, ifv_d;
  logic [WORDSIZE-1:0] inst_q, inst_d;
  logic [WORDSIZE-1:0] ipc_q, ipc_d;

  logic                redir;
  logic [WORDSIZE-1:0] redir_tgt;

  // Trap wins over redirect; branch targets are forced word-aligned.
  assign redir     = trap | redirect;
  assign redir_tgt = trap ? TRAP_VEC : {redirect_pc[WORDSIZE-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ifv_d   = ifv_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;

    // Any redirect flushes the buffer, even if decode is consuming it.
    if (redir) begin
      ifv_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (redir) begin
          pc_d = redir_tgt;
        end
        state_d = FETCH;
      end

      FETCH: begin
        if (redir) begin
          if (imem_ack) begin
            // Response arrives with the redirect: drop it, refetch at target.
            pc_d    = redir_tgt;
            state_d = FETCH;
          end else begin
            // Request is still outstanding at the old address; park the target.
            pend_d  = redir_tgt;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          inst_d  = imem_rdata;
          ipc_d   = pc_q;
          ifv_d   = 1'b1;
          pc_d    = pc_q + WORDSIZE'(4);
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (redir) begin
          pc_d    = redir_tgt;
          state_d = FETCH;
        end else if (id_ready) begin
          ifv_d   = 1'b0;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        // The newest target always wins, including one arriving with the ack.
        if (imem_ack) begin
          pc_d    = redir ? redir_tgt : pend_q;
          state_d = FETCH;
        end else if (redir) begin
          pend_d  = redir_tgt;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      ifv_q   <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ifv_q   <= ifv_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  // The address on the bus is the PC register itself, so it cannot move mid-request.
  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign if_valid  = ifv_q;
  assign if_inst   = inst_q;
  assign if_pc     = ipc_q;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap = 1'b0;
  logic [31:0] pc;

  fetch_seq dut (
    .CLK        (CLK),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .id_ready   (id_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .trap       (trap),
    .pc         (pc)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: is a request out, has it been redirected (its data is
  // junk and a target is waiting), and what sits in the decode buffer.
  logic        m_req = 1'b0;
  logic [31:0] m_pc = '0;
  logic        m_junk = 1'b0;
  logic [31:0] m_target = '0;
  logic        m_v = 1'b0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_ipc = '0;

  always @(posedge CLK) begin
    logic        jump;
    logic [31:0] dest;
    jump = trap || redirect;
    dest = trap ? 32'h100 : (redirect_pc & 32'hFFFF_FFFC);
    if (reset) begin
      m_req = 0; m_pc = 0; m_junk = 0; m_v = 0; m_inst = 0; m_ipc = 0;
    end else if (!m_req) begin
      // not fetching: just out of reset, or holding an instruction
      if (jump) begin
        m_pc = dest; m_v = 0; m_req = 1;
      end else if (!m_v || id_ready) begin
        m_v = 0; m_req = 1;
      end
    end else if (imem_ack) begin
      if (jump) begin
        m_pc = dest; m_junk = 0;
      end else if (m_junk) begin
        m_pc = m_target; m_junk = 0;
      end else begin
        m_inst = imem_rdata; m_ipc = m_pc; m_v = 1;
        m_pc = m_pc + 32'd4; m_req = 0;
      end
    end else if (jump) begin
      m_junk = 1; m_target = dest;
    end
  end

  // ---------------- compare process + transaction logs ----------------
  logic        run_cmp = 1'b0;
  logic        prev_v = 1'b0;
  logic [31:0] req_q[$];   // addresses of every request acknowledged (incl. discarded)
  logic [31:0] vld_q[$];   // if_pc of every instruction delivered to decode

  always @(negedge CLK) begin
    if (run_cmp) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_v});
      chk("if_inst", if_inst, m_inst);
      chk("if_pc", if_pc, m_ipc);
      if (imem_req && imem_ack && !reset) req_q.push_back(imem_addr);
      if (if_valid && !prev_v) vld_q.push_back(if_pc);
      prev_v = if_valid;
    end
  end

  function automatic logic [31:0] reqat(input int i);
    return (i < req_q.size()) ? req_q[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] vldat(input int i);
    return (i < vld_q.size()) ? vld_q[i] : 32'hDEAD_BEEF;
  endfunction

  // ---------------- stimulus ----------------
  logic        auto_ack = 1'b0;
  logic [31:0] stall_addr = '0;
  int          stall_cnt = 0;
  int          rb, vb;

  task automatic step();
    @(posedge CLK);
    #2;
    if (auto_ack) begin
      if (imem_req && imem_addr == stall_addr && stall_cnt > 0) begin
        imem_ack = 1'b0;
        stall_cnt--;
      end else begin
        imem_ack = imem_req;
      end
    end
    imem_rdata = 32'hC0DE_0000 ^ imem_addr;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1; redirect = 0; trap = 0; stall_cnt = 0; auto_ack = 1; imem_ack = 0;
    steps(2);
    rb = req_q.size(); vb = vld_q.size();
    reset = 0;
  endtask

  // Waits for the first stalled request cycle; an expired bound counts as a failure.
  task automatic wait_stall(input string nm);
    int k;
    k = 0;
    while (!(imem_req && !imem_ack) && k < 30) begin
      step(); k++;
    end
    chk(nm, {31'b0, (k < 30)}, 32'd1);
  endtask

  initial begin
    step();
    run_cmp = 1;
    do_reset();
    #3;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", pc, 32'd0);

    // 1: zero-wait memory, decode always ready
    id_ready = 1;
    steps(9);
    chk("t1_req0", reqat(rb + 0), 32'h0);
    chk("t1_req1", reqat(rb + 1), 32'h4);
    chk("t1_req2", reqat(rb + 2), 32'h8);
    chk("t1_req3", reqat(rb + 3), 32'hC);
    chk("t1_vld3", vldat(vb + 3), 32'hC);

    // 2: decode stalls after the first fetch
    do_reset();
    id_ready = 0;
    steps(7);
    @(negedge CLK); #1;
    chk("t2_valid", {31'b0, if_valid}, 32'd1);
    chk("t2_ifpc", if_pc, 32'h0);
    chk("t2_inst", if_inst, 32'hC0DE_0000);
    chk("t2_req", {31'b0, imem_req}, 32'd0);
    chk("t2_pc", pc, 32'h4);
    id_ready = 1;
    steps(4);
    chk("t2_req1", reqat(rb + 1), 32'h4);
    chk("t2_vld1", vldat(vb + 1), 32'h4);

    // 3: slow ack at 8 with a redirect in the first wait cycle
    do_reset();
    stall_addr = 32'h8; stall_cnt = 3;
    wait_stall("t3_stall_seen");
    chk("t3_addr_at_stall", imem_addr, 32'h8);
    redirect = 1; redirect_pc = 32'h203;
    step();
    redirect = 0;
    steps(2);
    @(negedge CLK); #1;
    chk("t3_drain_addr", imem_addr, 32'h8);
    steps(6);
    chk("t3_req2", reqat(rb + 2), 32'h8);
    chk("t3_req3", reqat(rb + 3), 32'h200);
    chk("t3_vld2", vldat(vb + 2), 32'h200);

    // 4: trap and redirect together in HOLD while decode is ready
    do_reset();
    id_ready = 0;
    steps(3);
    chk("t4_in_hold", {31'b0, if_valid}, 32'd1);
    trap = 1; redirect = 1; redirect_pc = 32'h40; id_ready = 1;
    step();
    trap = 0; redirect = 0;
    @(negedge CLK); #1;
    chk("t4_valid", {31'b0, if_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h100);
    steps(3);
    chk("t4_req1", reqat(rb + 1), 32'h100);

    // 5: PC wrap at the top of the address space
    do_reset();
    redirect = 1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 0;
    steps(4);
    chk("t5_req0", reqat(rb + 0), 32'hFFFF_FFFC);
    chk("t5_req1", reqat(rb + 1), 32'h0);
    chk("t5_vld0", vldat(vb + 0), 32'hFFFF_FFFC);

    // 6: reset while draining; a stray ack in IDLE is ignored
    do_reset();
    stall_addr = 32'h4; stall_cnt = 5;
    wait_stall("t6_stall_seen");
    redirect = 1; redirect_pc = 32'h300;
    step();
    redirect = 0;
    step();
    reset = 1;
    step();
    @(negedge CLK); #1;
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_valid", {31'b0, if_valid}, 32'd0);
    chk("t6_pc", pc, 32'h0);
    rb = req_q.size(); vb = vld_q.size();
    reset = 0; auto_ack = 0; imem_ack = 1;
    step();
    auto_ack = 1; stall_cnt = 0;
    @(negedge CLK); #1;
    chk("t6_resume_addr", imem_addr, 32'h0);
    steps(4);
    chk("t6_req0", reqat(rb + 0), 32'h0);
    chk("t6_vld0", vldat(vb + 0), 32'h0);

    steps(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-fetch sequencer that owns the program counter and drives it through the instruction-memory handshake. It increments the PC by 4 on each completed fetch and applies redirects from branch/jump resolution or traps. It also buffers one fetched instruction for decode. The block sits between the PC/next-PC datapath, instruction memory and the decode stage.

Parameters:
WORDSIZE, 32, datapath/address width in bits
RESET_VEC, 0, PC value loaded on reset
TRAP_VEC, 32'h00000100, PC value loaded on trap

Ports:
CLK  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  WORDSIZE  fetch address, always equal to pc register
imem_ack  in  1  memory response valid; imem_rdata valid this cycle
imem_rdata  in  WORDSIZE  fetched instruction word
if_valid  out  1  if_inst/if_pc hold a valid instruction for decode
if_inst  out  WORDSIZE  buffered instruction
if_pc  out  WORDSIZE  address of buffered instruction
id_ready  in  1  decode accepts buffered instruction this cycle
redirect  in  1  branch/jump taken; load redirect_pc
redirect_pc  in  WORDSIZE  redirect target (from branch-target adder)
trap  in  1  exception; load TRAP_VEC
pc  out  WORDSIZE  current fetch PC (registered)

Behaviour:
- Reset (sampled at CLK edge, overrides everything): pc=RESET_VEC, state=IDLE, imem_req=0, if_valid=0, if_inst=0, if_pc=0. Reset mid-transaction abandons any outstanding request; a following imem_ack is ignored while in IDLE.
- States: IDLE, FETCH, HOLD, DRAIN. imem_req=1 in FETCH and DRAIN only. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- IDLE: goes to FETCH on the next cycle.
- FETCH, imem_ack=1, no redirect/trap:
  - if_inst<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, go to HOLD.
- HOLD: if_valid=1 and buffer contents are stable.
  - id_ready=1: if_valid<=0, go to FETCH.
  - Otherwise stay in HOLD.
  - Peak throughput is one instruction per 2 cycles with a zero-wait memory.
- Handshake rule: imem_addr stays stable while imem_req=1 until imem_ack. A request is never withdrawn.
- Redirect sources:
  - trap has priority over redirect.
  - New PC = TRAP_VEC or redirect_pc with bits [1:0] forced to 0.
  - pc is loaded the next edge, if_valid<=0 (buffer flushed, even if id_ready=1 that cycle).
- State after a redirect/trap:
  - IDLE or HOLD: go to FETCH.
  - FETCH with imem_ack=1: data discarded, go to FETCH at new pc.
  - FETCH with imem_ack=0: new pc is held in a pending register, imem_addr keeps the old address, go to DRAIN.
  - DRAIN: imem_req=1 at old address.
    - imem_ack=1: data discarded, pc<=pending, go to FETCH.
    - A further redirect/trap in DRAIN overwrites pending; if it coincides with ack, the newest target wins.
- pc output during DRAIN shows the old (outstanding) address. The pending target becomes visible on exit.
- Arithmetic: pc+4 is modulo 2^WORDSIZE, so 32'hFFFFFFFC wraps to 0 with no flag.
- No fetch ever starts while if_valid=1 and id_ready=0 (single-entry buffer full).

Test Plan:
- Reset, then zero-wait memory with imem_ack=1 whenever imem_req, id_ready=1 -> imem_addr sequence 0,4,8,C; if_valid pulses on alternate cycles; if_pc matches each address.
- id_ready=0 for 5 cycles after the first fetch -> if_valid held, if_inst/if_pc unchanged, imem_req=0 throughout; release -> next fetch at addr 4.
- imem_ack delayed 3 cycles at addr 8; redirect=1, redirect_pc=32'h203 in the first wait cycle -> imem_addr stays 8 until ack; data discarded; next request at 32'h200; no if_valid for addr 8.
- trap=1 and redirect=1 same cycle in HOLD with id_ready=1 -> if_valid drops, next imem_addr=32'h100.
- pc=32'hFFFFFFFC, fetch completes -> pc=0, next imem_addr=0.
- reset asserted while in DRAIN with ack pending -> next cycle imem_req=0, if_valid=0, pc=0; fetch resumes at 0 two cycles after reset deasserts.
